life_sequencer: RTL and testbench
=================================

LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 SHALL have parameter GEN_W, default 16, generation counter width.
REQ-002 SHALL have parameter RATE_W, default 8, width of the generation-interval input.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port init_state  input  256  seed grid, row r at bits [16r+15:16r].
REQ-006 SHALL have port load  input  1  one-cycle pulse: capture init_state.
REQ-007 SHALL have port start  input  1  one-cycle pulse: begin free-running evolution.
REQ-008 SHALL have port stop  input  1  one-cycle pulse: pause evolution.
REQ-009 SHALL have port step  input  1  one-cycle pulse: advance exactly one generation while paused.
REQ-010 SHALL have port rate  input  RATE_W  idle cycles between generations in RUN.
REQ-011 SHALL have port grid_evolve  input  256  next generation from the combinational datapath.
REQ-012 SHALL have port grid  output  256  registered current generation, driven to the datapath.
REQ-013 SHALL have port gen_count  output  GEN_W  generations applied since last load.
REQ-014 SHALL have port running  output  1  high while in RUN.
REQ-015 SHALL have port stable  output  1  combinational: grid_evolve == grid.
REQ-016 SHALL have port extinct  output  1  combinational: grid == 0.
REQ-017 SHALL have port halted  output  1  high while in HALT.

Function
REQ-018 SHALL implement states IDLE, RUN, HALT, held in a state register.
REQ-019 Command priority SHALL be load > stop > start > step when pulses coincide.
REQ-020 load, in any state, SHALL set grid<=init_state, gen_count<=0, interval counter<=0, state<=IDLE on the next edge.
REQ-021 IDLE: start -> RUN with interval counter 0; step -> grid<=grid_evolve, gen_count+1, remain IDLE.
REQ-022 RUN: interval counter increments each cycle; when counter == rate, grid<=grid_evolve, gen_count+1, counter<=0.
REQ-023 rate=0 SHALL apply one generation every cycle in RUN; rate=N yields one generation per N+1 cycles.
REQ-024 rate SHALL be sampled every cycle; a change mid-interval takes effect on the next compare.
REQ-025 RUN: stop -> IDLE, counter<=0, no generation applied that cycle even if counter == rate.
REQ-026 step SHALL be ignored in RUN and HALT; start SHALL be ignored in RUN and HALT.
REQ-027 gen_count SHALL saturate at 2^GEN_W-1; grid continues to evolve at saturation.
REQ-028 Generation latency: grid_evolve sampled on the edge after the qualifying cycle; grid valid the following cycle.

Reset
REQ-029 reset SHALL override all commands and, on the next edge, set grid=0, gen_count=0, counter=0, state=IDLE.
REQ-030 After reset: running=0, halted=0, extinct=1; stable follows grid_evolve.
REQ-031 reset mid-RUN SHALL discard any pending generation.

Configuration
REQ-032 With LIFE_AUTOSTOP_EN defined, RUN SHALL go to HALT instead of applying a generation when the apply condition holds and stable or extinct is 1; grid and gen_count unchanged.
REQ-033 With LIFE_AUTOSTOP_EN defined, HALT SHALL exit only via load (-> IDLE) or reset.
REQ-034 Without LIFE_AUTOSTOP_EN, HALT SHALL be unreachable, halted tied 0, and RUN continues through stable/extinct grids.

Verification
REQ-035 reset, then load with init_state 256'h0412_6424_0034_3C28 repeated x4 -> grid equals it, gen_count=0, running=0.
REQ-036 Blinker (row 1 bits 2:0 = 3'b111), start, rate=0 -> gen_count 1,2,3 on consecutive cycles; grid alternates vertical/horizontal.
REQ-037 rate=3, start -> generations at cycles 4, 8, 12 after start; stop on cycle 7 -> gen_count=1, no further update.
REQ-038 load and start asserted together in RUN -> grid=init_state, gen_count=0, state IDLE.
REQ-039 LIFE_AUTOSTOP_EN defined, 2x2 block still-life, start -> halted=1 at first compare, gen_count=0; start ignored; load clears halted.
REQ-040 IDLE, step x3 with a glider -> gen_count=3, grid equals datapath third generation; step during RUN ignored.

Source files
------------

// File: rtl/life_sequencer.sv
// Control sequencer for a 16x16 Game of Life grid: holds the current generation,
// paces evolution (load/start/stop/step/rate). Optional macro: LIFE_AUTOSTOP_EN.
module life_sequencer #(
    parameter int GEN_W  = 16,
    parameter int RATE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [255:0]      init_state,
    input  logic              load,
    input  logic              start,
    input  logic              stop,
    input  logic              step,
    input  logic [RATE_W-1:0] rate,
    input  logic [255:0]      grid_evolve,
    output logic [255:0]      grid,
    output logic [GEN_W-1:0]  gen_count,
    output logic              running,
    output logic              stable,
    output logic              extinct,
    output logic              halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [255:0]        grid_q, grid_d;
    logic [GEN_W-1:0]    gen_q, gen_d;
    logic [RATE_W-1:0]   cnt_q, cnt_d;
    logic                apply_gen;
    logic                at_compare;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grid_q  <= '0;
            gen_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grid_q  <= grid_d;
            gen_q   <= gen_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command priority is load > stop > start > step; a stop in IDLE still masks start/step.
    always_comb begin
        state_d    = state_q;
        grid_d     = grid_q;
        gen_d      = gen_q;
        cnt_d      = cnt_q;
        apply_gen  = 1'b0;
        at_compare = (cnt_q == rate);

        if (load) begin
            grid_d  = init_state;
            gen_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else if (start) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else if (step) begin
                        apply_gen = 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (at_compare) begin
                        cnt_d = '0;
`ifdef LIFE_AUTOSTOP_EN
                        if (stable || extinct) begin
                            state_d = HALT;
                        end else begin
                            apply_gen = 1'b1;
                        end
`else
                        apply_gen = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // The grid keeps evolving even once the generation count has saturated.
        if (apply_gen) begin
            grid_d = grid_evolve;
            gen_d  = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + 1'b1;
        end
    end

    assign grid      = grid_q;
    assign gen_count = gen_q;
    assign running   = (state_q == RUN);
    assign stable    = (grid_evolve == grid_q);
    assign extinct   = (grid_q == '0);
`ifdef LIFE_AUTOSTOP_EN
    assign halted    = (state_q == HALT);
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_life_sequencer.sv
// Table-driven bench for life_sequencer; a behavioural Life rule (dead border)
// plays the role of the external grid_evolve datapath.
module tb_life_sequencer;

    localparam int GEN_W  = 4;
    localparam int RATE_W = 8;

    logic              clk;
    logic              reset;
    logic [255:0]      initState;
    logic              load, start, stop, step;
    logic [RATE_W-1:0] rate;
    logic [255:0]      gridEvolve;
    logic [255:0]      grid;
    logic [GEN_W-1:0]  genCount;
    logic              running, stable, extinct, halted;

    int testCount;
    int failCount;

    life_sequencer #(.GEN_W(GEN_W), .RATE_W(RATE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .init_state  (initState),
        .load        (load),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .rate        (rate),
        .grid_evolve (gridEvolve),
        .grid        (grid),
        .gen_count   (genCount),
        .running     (running),
        .stable      (stable),
        .extinct     (extinct),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] lifeNext(input logic [255:0] g);
        logic [255:0] n;
        int           cnt;
        int           rr, cc;
        n = '0;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
                            cnt += int'(g[rr*16+cc]);
                    end
                end
                n[r*16+c] = (cnt == 3) || (g[r*16+c] && cnt == 2);
            end
        end
        return n;
    endfunction

    always_comb gridEvolve = lifeNext(grid);

    typedef struct {
        string        name;
        logic         ld, st, sp, stp;
        logic [7:0]   rt;
        logic [255:0] init;
        logic [3:0]   expGen;
        logic         expRun;
        logic [255:0] expGrid;
    } vector_t;

    vector_t vecs[$];

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of command inputs, then sample #1 after the edge.
    task automatic applyStimulus(input logic ld, input logic st, input logic sp, input logic stp,
                                 input logic [7:0] rt, input logic [255:0] init);
        load      = ld;
        start     = st;
        stop      = sp;
        step      = stp;
        rate      = rt;
        initState = init;
        @(posedge clk);
        #1;
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        step  = 1'b0;
    endtask

    task automatic checkState(input string name, input logic [3:0] eGen, input logic eRun, input logic [255:0] eGrid);
        checkOutput({name, ".gen"}, {252'b0, genCount}, {252'b0, eGen});
        checkOutput({name, ".running"}, {255'b0, running}, {255'b0, eRun});
        checkOutput({name, ".grid"}, grid, eGrid);
    endtask

    function automatic void addVec(input string nm, input logic ld, input logic st, input logic sp,
                                   input logic stp, input logic [7:0] rt, input logic [255:0] init,
                                   input logic [3:0] eg, input logic er, input logic [255:0] egr);
        vector_t v;
        v.name = nm; v.ld = ld; v.st = st; v.sp = sp; v.stp = stp; v.rt = rt;
        v.init = init; v.expGen = eg; v.expRun = er; v.expGrid = egr;
        vecs.push_back(v);
    endfunction

    logic [255:0] seedA, blinkH, blinkV, glider, glider3, block;

    initial begin
        testCount = 0;
        failCount = 0;
        reset = 1'b1; load = 0; start = 0; stop = 0; step = 0; rate = '0; initState = '0;

        seedA   = {4{64'h0412_6424_0034_3C28}};
        blinkH  = 256'h0007 << 16;
        blinkV  = (256'h0002) | (256'h0002 << 16) | (256'h0002 << 32);
        glider  = (256'h0008 << 32) | (256'h0010 << 48) | (256'h001C << 64);
        glider3 = lifeNext(lifeNext(lifeNext(glider)));
        block   = (256'h0060 << 80) | (256'h0060 << 96);

        //      name              ld st sp stp rate init    gen run grid
        addVec("loadSeed",        1, 0, 0, 0, 0, seedA,  0, 0, seedA);
        addVec("idleHold",        0, 0, 0, 0, 0, '0,     0, 0, seedA);
        addVec("idleStopStart",   0, 1, 1, 0, 0, '0,     0, 0, seedA);
        addVec("loadBlink",       1, 0, 0, 0, 0, blinkH, 0, 0, blinkH);
        addVec("startRate0",      0, 1, 0, 0, 0, '0,     0, 1, blinkH);
        addVec("run1",            0, 0, 0, 0, 0, '0,     1, 1, blinkV);
        addVec("run2",            0, 0, 0, 0, 0, '0,     2, 1, blinkH);
        addVec("run3",            0, 0, 0, 0, 0, '0,     3, 1, blinkV);
        addVec("stopRun",         0, 0, 1, 0, 0, '0,     3, 0, blinkV);
        addVec("idleStep",        0, 0, 0, 1, 0, '0,     4, 0, blinkH);
        addVec("startAgain",      0, 1, 0, 0, 0, '0,     4, 1, blinkH);
        addVec("runAgain",        0, 0, 0, 0, 0, '0,     5, 1, blinkV);
        addVec("loadStartInRun",  1, 1, 0, 0, 0, seedA,  0, 0, seedA);
        addVec("startStepIdle",   0, 1, 0, 1, 5, '0,     0, 1, seedA);
        addVec("stepInRun",       0, 0, 0, 1, 5, '0,     0, 1, seedA);
        addVec("startInRun",      0, 1, 0, 0, 5, '0,     0, 1, seedA);
        addVec("stopStartRun",    0, 1, 1, 0, 5, '0,     0, 0, seedA);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkState("reset", 0, 0, '0);
        checkOutput("reset.halted", {255'b0, halted}, 256'd0);
        checkOutput("reset.extinct", {255'b0, extinct}, 256'd1);
        checkOutput("reset.stable", {255'b0, stable}, 256'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].sp, vecs[i].stp, vecs[i].rt, vecs[i].init);
            checkState(vecs[i].name, vecs[i].expGen, vecs[i].expRun, vecs[i].expGrid);
        end

        // rate=3: a generation lands every fourth edge after start.
        applyStimulus(1, 0, 0, 0, 3, blinkH);
        applyStimulus(0, 1, 0, 0, 3, '0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(0, 0, 0, 0, 3, '0);
            checkOutput($sformatf("rate3.k%0d", k), {252'b0, genCount}, 256'(k / 4));
        end
        applyStimulus(0, 0, 1, 0, 3, '0);

        // rate=3 with stop sampled on edge 7: only one generation survives.
        applyStimulus(1, 0, 0, 0, 3, blinkH);
        applyStimulus(0, 1, 0, 0, 3, '0);
        for (int k = 1; k <= 7; k++)
            applyStimulus(0, 0, (k == 7), 0, 3, '0);
        checkState("rate3Stop", 1, 0, blinkV);
        repeat (6) applyStimulus(0, 0, 0, 0, 3, '0);
        checkState("rate3StopHold", 1, 0, blinkV);

        // Lowering rate mid-interval takes effect at the next compare.
        applyStimulus(1, 0, 0, 0, 4, blinkH);
        applyStimulus(0, 1, 0, 0, 4, '0);
        applyStimulus(0, 0, 0, 0, 4, '0);
        applyStimulus(0, 0, 0, 0, 4, '0);
        checkOutput("rateChange.before", {252'b0, genCount}, 256'd0);
        applyStimulus(0, 0, 0, 0, 2, '0);
        checkState("rateChange.after", 1, 1, blinkV);
        applyStimulus(0, 0, 1, 0, 2, '0);

        // Generation count saturates but the grid keeps evolving.
        applyStimulus(1, 0, 0, 0, 0, blinkH);
        applyStimulus(0, 1, 0, 0, 0, '0);
        repeat (20) applyStimulus(0, 0, 0, 0, 0, '0);
        checkState("saturate", 15, 1, blinkH);
        applyStimulus(0, 0, 0, 0, 0, '0);
        checkState("saturateEvolve", 15, 1, blinkV);
        applyStimulus(0, 0, 1, 0, 0, '0);

        // Glider stepped three times from IDLE.
        applyStimulus(1, 0, 0, 0, 0, glider);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(0, 0, 0, 1, 0, '0);
            checkOutput($sformatf("gliderStep%0d", k), {252'b0, genCount}, 256'(k));
        end
        checkOutput("glider3.grid", grid, glider3);
        checkOutput("glider3.extinct", {255'b0, extinct}, 256'd0);
        checkOutput("glider3.stable", {255'b0, stable}, 256'd0);

        // Reset with a generation pending (counter == rate) and a coincident load.
        applyStimulus(1, 0, 0, 0, 1, blinkH);
        applyStimulus(0, 1, 0, 0, 1, '0);
        applyStimulus(0, 0, 0, 0, 1, '0);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 0, 1, seedA);
        reset = 1'b0;
        checkState("resetMidRun", 0, 0, '0);
        checkOutput("resetMidRun.extinct", {255'b0, extinct}, 256'd1);
        applyStimulus(0, 0, 0, 0, 1, '0);
        checkState("resetMidRunAfter", 0, 0, '0);

        // Still-life block: halts under autostop, otherwise keeps counting.
        applyStimulus(1, 0, 0, 0, 0, block);
        applyStimulus(0, 1, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, 0, '0);
`ifdef LIFE_AUTOSTOP_EN
        checkState("autostop", 0, 0, block);
        checkOutput("autostop.halted", {255'b0, halted}, 256'd1);
        applyStimulus(0, 1, 0, 1, 0, '0);
        checkOutput("autostopStart.halted", {255'b0, halted}, 256'd1);
        checkState("autostopStart", 0, 0, block);
        applyStimulus(1, 0, 0, 0, 0, block);
        checkOutput("autostopLoad.halted", {255'b0, halted}, 256'd0);
        checkState("autostopLoad", 0, 0, block);
`else
        applyStimulus(0, 0, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 0, 0, '0);
        checkState("stillLife", 3, 1, block);
        checkOutput("stillLife.halted", {255'b0, halted}, 256'd0);
        checkOutput("stillLife.stable", {255'b0, stable}, 256'd1);
        applyStimulus(0, 0, 1, 0, 0, '0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
